// File: rtl/lb2apb_pkg.sv
// Shared types and constants for the local-bus to APB4 bridge.
package lb2apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/lb2apb_if.sv
// Local-bus request/completion interface and APB4 initiator interface for lb2apb.
interface lb2apb_lb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wen;
  logic              wready;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (output waddr, wdata, wstrb, wen, raddr, ren,
                  input  wready, rdata, rvalid, err);
  modport slave  (input  waddr, wdata, wstrb, wen, raddr, ren,
                  output wready, rdata, rvalid, err);
endinterface

interface lb2apb_apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [2:0]        pprot;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/lb2apb.sv
// Bridges held local-bus write/read requests onto a single-outstanding APB4 transfer,
// returning a one-cycle completion pulse with error status.
module lb2apb
  import lb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  lb2apb_lb_if.slave   lb,
  lb2apb_apb_if.master apb
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CntW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_hit;

  // cnt_q counts completed wait cycles, so the limit hits on the TIMEOUT-th ACCESS cycle
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lb.wen) begin
          state_d  = StSetup;
          paddr_d  = lb.waddr;
          pwrite_d = 1'b1;
          pwdata_d = lb.wdata;
          pstrb_d  = lb.wstrb;
        end else if (lb.ren) begin
          state_d  = StSetup;
          paddr_d  = lb.raddr;
          pwrite_d = 1'b0;
          pwdata_d = lb.wdata;
          pstrb_d  = '0;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (apb.pready) begin
          state_d = StResp;
          rdata_d = apb.prdata;
          err_d   = apb.pslverr;
        end else if (timeout_hit) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode from state_q so reset clears them without waiting for a clock
  assign apb.psel    = (state_q == StSetup) || (state_q == StAccess);
  assign apb.penable = (state_q == StAccess);
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.pprot   = PPROT_DEFAULT;

  assign lb.wready = (state_q == StResp) && pwrite_q;
  assign lb.rvalid = (state_q == StResp) && !pwrite_q;
  assign lb.err    = (state_q == StResp) && err_q;
  assign lb.rdata  = lb.rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_lb2apb.sv
// Directed bench for lb2apb: a vector table of single transfers plus hand sequences for
// simultaneous requests, APB timeout and reset during ACCESS.
module tb_lb2apb;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;
    logic [31:0] prdata;
    bit          slverr;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lb2apb_lb_if  #(.ADDR_W(32), .DATA_W(32)) lb ();
  lb2apb_apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();
  lb2apb_lb_if  #(.ADDR_W(32), .DATA_W(32)) lb_to ();
  lb2apb_apb_if #(.ADDR_W(32), .DATA_W(32)) apb_to ();

  lb2apb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .lb  (lb),
    .apb (apb)
  );

  lb2apb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .lb  (lb_to),
    .apb (apb_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plays the APB slave from SETUP until the completion pulse; noise is driven whenever
  // the bridge must ignore pready/prdata/pslverr.
  task automatic run_access(input int ws, input logic [31:0] prd, input bit slv,
                            output int acc, output bit got);
    bit          leak  = 1'b0;
    bit          moved = 1'b0;
    logic [31:0] a0    = apb.paddr;
    logic [31:0] d0    = apb.pwdata;
    acc = 0;
    got = 1'b0;
    apb.pready  = 1'b1;
    apb.prdata  = ~prd;
    apb.pslverr = 1'b1;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (lb.wready || lb.rvalid) begin
        got = 1'b1;
      end else begin
        if (!(apb.psel && apb.penable) || apb.paddr != a0 || apb.pwdata != d0) moved = 1'b1;
        if (lb.rdata != 32'h0 || lb.err) leak = 1'b1;
        apb.pready  = (acc == ws);
        apb.prdata  = (acc == ws) ? prd : ~prd;
        apb.pslverr = (acc == ws) ? slv : ~slv;
        acc++;
      end
    end
    apb.pready  = 1'b1;
    apb.prdata  = ~prd;
    apb.pslverr = 1'b1;
    chk("access_stable", {63'h0, moved}, 64'h0);
    chk("no_early_completion", {63'h0, leak}, 64'h0);
    chk("completion_seen", {63'h0, got}, 64'h1);
  endtask

  task automatic xfer(input vec_t v);
    int acc;
    bit got;
    @(negedge clk);
    if (v.wr) begin
      lb.waddr = v.addr;  lb.wdata = v.wdata; lb.wstrb = v.strb; lb.raddr = ~v.addr;
      lb.wen   = 1'b1;
    end else begin
      lb.raddr = v.addr;  lb.waddr = ~v.addr; lb.wdata = v.wdata; lb.wstrb = 4'hF;
      lb.ren   = 1'b1;
    end
    @(negedge clk);
    chk("setup_phase", {62'h0, apb.psel, apb.penable}, 64'h2);
    chk("setup_paddr", {32'h0, apb.paddr}, {32'h0, v.addr});
    chk("setup_pwrite", {63'h0, apb.pwrite}, {63'h0, v.wr});
    chk("setup_pstrb", {60'h0, apb.pstrb}, {60'h0, (v.wr ? v.strb : 4'h0)});
    chk("setup_pprot", {61'h0, apb.pprot}, 64'h0);
    if (v.wr) chk("setup_pwdata", {32'h0, apb.pwdata}, {32'h0, v.wdata});
    run_access(v.ws, v.prdata, v.slverr, acc, got);
    chk("access_cycles", 64'(acc), 64'(v.ws + 1));
    chk("resp_flags", {60'h0, lb.wready, lb.rvalid, lb.err, apb.psel},
        {60'h0, v.wr, !v.wr, v.exp_err, 1'b0});
    chk("resp_rdata", {32'h0, lb.rdata}, {32'h0, v.exp_rdata});
    @(negedge clk);
    // request was still high across the RESP edge; it must not have restarted
    chk("single_pulse", {60'h0, lb.wready, lb.rvalid, lb.err, apb.psel}, 64'h0);
    chk("rdata_zero_after", {32'h0, lb.rdata}, 64'h0);
    lb.wen = 1'b0;
    lb.ren = 1'b0;
    @(negedge clk);
    chk("idle_after", {63'h0, apb.psel}, 64'h0);
  endtask

  vec_t vecs[6];

  initial begin
    int  acc;
    bit  got;
    bit  seen;
    checks   = 0;
    failures = 0;
    vecs[0] = '{1'b1, 32'h8000_0004, 32'hdead_beef, 4'hF, 0,   32'h0,         1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b1, 32'h0000_000c, 32'hcafe_babe, 4'h6, 800, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 5,   32'hc0de_babe, 1'b0, 32'hc0de_babe, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 2,   32'h0,         1'b1, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 0,   32'h5a5a_5a5a, 1'b1, 32'h5a5a_5a5a, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0028, 32'h0,         4'h0, 1,   32'ha5a5_0001, 1'b0, 32'ha5a5_0001, 1'b0};

    rst = 1'b0;
    lb.waddr = '0; lb.wdata = '0; lb.wstrb = '0; lb.wen = 1'b0; lb.raddr = '0; lb.ren = 1'b0;
    lb_to.waddr = '0; lb_to.wdata = '0; lb_to.wstrb = '0; lb_to.wen = 1'b0;
    lb_to.raddr = '0; lb_to.ren = 1'b0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    apb_to.pready = 1'b0; apb_to.prdata = 32'hffff_ffff; apb_to.pslverr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_apb", {59'h0, apb.psel, apb.penable, apb.pwrite, apb.pstrb == 4'h0,
        apb.pprot == 3'h0}, 64'h3);
    chk("reset_lb", {61'h0, lb.wready, lb.rvalid, lb.err}, 64'h0);
    chk("reset_rdata", {32'h0, lb.rdata}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) xfer(vecs[i]);

    // wen and ren together: write first, read left pending, two APB transfers
    @(negedge clk);
    lb.waddr = 32'h010; lb.wdata = 32'h0bad_f00d; lb.wstrb = 4'hF; lb.wen = 1'b1;
    lb.raddr = 32'h008; lb.ren = 1'b1;
    @(negedge clk);
    chk("both_first_is_write", {31'h0, apb.psel, apb.pwrite, apb.paddr},
        {31'h0, 1'b1, 1'b1, 32'h010});
    run_access(0, 32'h0, 1'b0, acc, got);
    chk("both_wready", {62'h0, lb.wready, lb.rvalid}, 64'h2);
    @(negedge clk);
    lb.wen = 1'b0;
    chk("both_gap_idle", {63'h0, apb.psel}, 64'h0);
    @(negedge clk);
    chk("both_second_is_read", {27'h0, apb.psel, apb.pwrite, apb.pstrb, apb.paddr},
        {27'h0, 1'b1, 1'b0, 4'h0, 32'h008});
    run_access(0, 32'h1122_3344, 1'b0, acc, got);
    chk("both_rvalid", {30'h0, lb.wready, lb.rvalid, lb.rdata}, {30'h0, 2'b01, 32'h1122_3344});
    @(negedge clk);
    lb.ren = 1'b0;

    // Timeout instance: slave never answers
    @(negedge clk);
    lb_to.raddr = 32'h030; lb_to.ren = 1'b1;
    acc = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (lb_to.rvalid) got = 1'b1;
      else if (apb_to.penable) acc++;
    end
    chk("to_completion_seen", {63'h0, got}, 64'h1);
    chk("to_access_cycles", 64'(acc), 64'd16);
    chk("to_resp", {61'h0, lb_to.rvalid, lb_to.err, lb_to.wready}, 64'h6);
    chk("to_rdata", {32'h0, lb_to.rdata}, 64'h0);
    @(negedge clk);
    lb_to.ren = 1'b0;
    chk("to_single_pulse", {62'h0, lb_to.rvalid, lb_to.err}, 64'h0);

    // Reset while the write sits in ACCESS
    @(negedge clk);
    apb.pready = 1'b0;
    lb.waddr = 32'h040; lb.wdata = 32'h7777_0000; lb.wstrb = 4'hF; lb.wen = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_access", {62'h0, apb.psel, apb.penable}, 64'h3);
    #2 rst = 1'b0;
    #1;
    chk("reset_async_drop", {62'h0, apb.psel, apb.penable}, 64'h0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (lb.wready || lb.rvalid || apb.psel) seen = 1'b1;
    end
    lb.wen = 1'b0;
    rst    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (lb.wready || lb.rvalid || apb.psel) seen = 1'b1;
    end
    chk("no_pulse_after_reset", {63'h0, seen}, 64'h0);
    xfer('{1'b1, 32'h044, 32'h1357_9bdf, 4'h9, 1, 32'h0, 1'b0, 32'h0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
